clip_scheduler: RTL and testbench

//  Round-robin scheduler sharing one pixel clip stage (arith >>SHIFT, clamp 0..255) among NUM_REQ interpolation lanes.

---
 rtl/clip_scheduler.sv | 241 ++++++++++++++++++++++++
 tb/tb_clip_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clip_scheduler.sv
// clip_scheduler: round-robin sharing of one clip stage (>>SHIFT, clamp 0..255) among NUM_REQ lanes for one frame.
// Optional clamp statistics (stat_clear/stat_neg_cnt/stat_sat_cnt) are built when CLIP_STATS_EN is defined.
module clip_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 20,
  parameter int SHIFT   = 7,
  parameter int CNT_W   = 20,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        frame_pixels,
  output logic                    busy,
  output logic                    done,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_pixel,
  output logic [SRC_W-1:0]        out_src,
  output logic                    out_last
`ifdef CLIP_STATS_EN
  ,
  input  logic                    stat_clear,
  output logic [15:0]             stat_neg_cnt,
  output logic [15:0]             stat_sat_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [CNT_W-1:0]   remaining_r;
  logic [SRC_W-1:0]   rr_ptr_r;
  logic [SRC_W-1:0]   ptr_next_s;
  logic               grant_found_s;
  logic [SRC_W-1:0]   grant_idx_s;
  logic [IN_W-1:0]    grant_data_s;
  logic [SRC_W:0]     cand_s;
  logic [SRC_W-1:0]   cand_idx_s;
  logic               can_load_s;
  logic               accept_s;
  logic               out_hs_s;
  logic               zero_start_s;
  logic               frame_start_s;
  logic               frame_end_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic               busy_r;
  logic               done_r;
  logic               out_valid_r;
  logic [7:0]         out_pixel_r;
  logic [SRC_W-1:0]   out_src_r;
  logic               out_last_r;

  // Negative inputs clamp to 0; anything whose shifted value exceeds 255 saturates.
  function automatic logic [7:0] clip_pixel(input logic [IN_W-1:0] x);
    logic [IN_W-1:0] s;
    s = x >> SHIFT;
    if (x[IN_W-1]) begin
      clip_pixel = 8'd0;
    end else if (s > IN_W'(255)) begin
      clip_pixel = 8'hFF;
    end else begin
      clip_pixel = s[7:0];
    end
  endfunction

`ifdef CLIP_STATS_EN
  function automatic logic clip_is_neg(input logic [IN_W-1:0] x);
    clip_is_neg = x[IN_W-1];
  endfunction

  function automatic logic clip_is_sat(input logic [IN_W-1:0] x);
    clip_is_sat = !x[IN_W-1] && ((x >> SHIFT) > IN_W'(255));
  endfunction
`endif

  // Round-robin search for the first valid lane at or after the pointer, plus the winner's data.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {SRC_W{1'b0}};
    cand_s        = {(SRC_W+1){1'b0}};
    cand_idx_s    = {SRC_W{1'b0}};
    grant_data_s  = {IN_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (SRC_W+1)'(k);
      if (cand_s >= (SRC_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (SRC_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = cand_s[SRC_W-1:0];
      if (!grant_found_s && req_valid[cand_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == SRC_W'(i)) begin
        grant_data_s = req_data[i*IN_W +: IN_W];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
    if (grant_idx_s == SRC_W'(NUM_REQ - 1)) begin
      ptr_next_s = {SRC_W{1'b0}};
    end else begin
      ptr_next_s = grant_idx_s + SRC_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_start_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && (remaining_r == CNT_W'(1))) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (frame_end_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output logic: the grant only fires when the output register is free or emptying this cycle.
  always_comb begin
    can_load_s    = !out_valid_r || out_ready;
    out_hs_s      = out_valid_r && out_ready;
    zero_start_s  = (state_r == ST_IDLE) && start && (frame_pixels == {CNT_W{1'b0}});
    frame_start_s = (state_r == ST_IDLE) && start && (frame_pixels != {CNT_W{1'b0}});
    frame_end_s   = (state_r == ST_DRAIN) && out_hs_s && out_last_r;
    req_ready_s   = {NUM_REQ{1'b0}};
    if ((state_r == ST_RUN) && grant_found_s && can_load_s) begin
      accept_s                 = 1'b1;
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Output pixel register, frame counter, round-robin pointer and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_r <= {CNT_W{1'b0}};
      rr_ptr_r    <= {SRC_W{1'b0}};
      out_valid_r <= 1'b0;
      out_pixel_r <= 8'd0;
      out_src_r   <= {SRC_W{1'b0}};
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        out_pixel_r <= clip_pixel(grant_data_s);
        out_src_r   <= grant_idx_s;
        out_last_r  <= (remaining_r == CNT_W'(1));
        out_valid_r <= 1'b1;
        rr_ptr_r    <= ptr_next_s;
        remaining_r <= remaining_r - CNT_W'(1);
      end else if (frame_start_s) begin
        remaining_r <= frame_pixels;
      end else if (out_hs_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= zero_start_s || frame_end_s;
    end
  end

`ifdef CLIP_STATS_EN
  logic [15:0] stat_neg_r;
  logic [15:0] stat_sat_r;

  // Saturating clamp counters; they survive across frames and are zeroed only by reset or stat_clear.
  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      stat_neg_r <= 16'd0;
      stat_sat_r <= 16'd0;
    end else begin
      if (accept_s && clip_is_neg(grant_data_s) && (stat_neg_r != 16'hFFFF)) begin
        stat_neg_r <= stat_neg_r + 16'd1;
      end else begin
        stat_neg_r <= stat_neg_r;
      end
      if (accept_s && clip_is_sat(grant_data_s) && (stat_sat_r != 16'hFFFF)) begin
        stat_sat_r <= stat_sat_r + 16'd1;
      end else begin
        stat_sat_r <= stat_sat_r;
      end
    end
  end

  assign stat_neg_cnt = stat_neg_r;
  assign stat_sat_cnt = stat_sat_r;
`endif

  assign busy      = busy_r;
  assign done      = done_r;
  assign req_ready = req_ready_s;
  assign out_valid = out_valid_r;
  assign out_pixel = out_pixel_r;
  assign out_src   = out_src_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_clip_scheduler.sv
// Bench for clip_scheduler: frame-level reference model compared every cycle, plus literal expectations per scenario.
// Stat checks are compiled when CLIP_STATS_EN is defined.
module tb_clip_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] frame_pixels;
  logic        busy;
  logic        done;
  logic [3:0]  req_valid;
  logic [79:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pixel;
  logic [1:0]  out_src;
  logic        out_last;
`ifdef CLIP_STATS_EN
  logic        stat_clear;
  logic [15:0] stat_neg_cnt;
  logic [15:0] stat_sat_cnt;
`endif

  clip_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .frame_pixels(frame_pixels),
    .busy(busy), .done(done), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_src(out_src), .out_last(out_last)
`ifdef CLIP_STATS_EN
    , .stat_clear(stat_clear), .stat_neg_cnt(stat_neg_cnt), .stat_sat_cnt(stat_sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  bit          chk_en = 1'b0;
  logic [19:0] lane_q [4][$];
  logic [3:0]  hs = 4'b0000;
  int          ncyc = 0;
  int          done_cnt = 0;
  int          got_pix[$];
  int          got_src[$];
  int          got_last[$];
  int          got_cyc[$];

  // reference model state
  int          m_state = 0;
  int          m_rem = 0;
  int          m_ptr = 0;
  bit          m_ov = 1'b0;
  int          m_pix = 0;
  int          m_src = 0;
  bit          m_last = 1'b0;
  bit          m_done = 1'b0;
  int          m_neg = 0;
  int          m_sat = 0;
  int          g;
  logic [1:0]  idx;
  logic [3:0]  exp_rdy;
  logic [19:0] gdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int mclip(input logic [19:0] x);
    int v;
    v = int'({12'd0, x});
    if (v >= 524288) return 0;
    v = v / 128;
    if (v > 255) return 255;
    return v;
  endfunction

  // Compare DUT against the model, then advance the model with the inputs the next edge will sample.
  always @(negedge clk) begin
    hs = req_valid & req_ready;
    ncyc++;
    if (done === 1'b1) done_cnt++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      got_pix.push_back(int'(out_pixel));
      got_src.push_back(int'(out_src));
      got_last.push_back(int'(out_last));
      got_cyc.push_back(ncyc);
    end
    g = -1;
    if (m_state == 1 && (!m_ov || out_ready)) begin
      for (int k = 0; k < 4; k++) begin
        idx = 2'(m_ptr + k);
        if (g < 0 && req_valid[idx]) g = int'(idx);
      end
    end
    exp_rdy = (g >= 0) ? 4'(4'b0001 << g) : 4'b0000;
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_state != 0));
      check("done", 32'(done), 32'(m_done));
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        check("out_pixel", 32'(out_pixel), 32'(m_pix));
        check("out_src", 32'(out_src), 32'(m_src));
        check("out_last", 32'(out_last), 32'(m_last));
      end
`ifdef CLIP_STATS_EN
      check("stat_neg", 32'(stat_neg_cnt), 32'(m_neg));
      check("stat_sat", 32'(stat_sat_cnt), 32'(m_sat));
`endif
    end
    if (rst) begin
      m_state = 0; m_rem = 0; m_ptr = 0; m_ov = 1'b0; m_pix = 0; m_src = 0;
      m_last = 1'b0; m_done = 1'b0; m_neg = 0; m_sat = 0;
    end else begin
      m_done = 1'b0;
      if (m_state == 0 && start) begin
        if (frame_pixels == 20'd0) m_done = 1'b1;
        else begin m_state = 1; m_rem = int'(frame_pixels); end
      end else if (m_state == 2 && m_ov && out_ready && m_last) begin
        m_state = 0;
        m_done = 1'b1;
      end
`ifdef CLIP_STATS_EN
      if (stat_clear) begin m_neg = 0; m_sat = 0; end
`endif
      if (g >= 0) begin
        gdata = req_data[g*20 +: 20];
        m_pix = mclip(gdata);
        m_src = g;
        m_last = (m_rem == 1);
        m_ov = 1'b1;
        m_ptr = (g + 1) % 4;
        if (m_rem == 1) m_state = 2;
        m_rem = m_rem - 1;
`ifdef CLIP_STATS_EN
        if (!stat_clear) begin
          if (gdata >= 20'h80000) m_neg = (m_neg < 65535) ? m_neg + 1 : m_neg;
          else if (gdata / 128 > 255) m_sat = (m_sat < 65535) ? m_sat + 1 : m_sat;
        end
`endif
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      if (lane_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*20 +: 20] = lane_q[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*20 +: 20] = 20'd0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
    end
    refresh();
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) lane_q[i].delete();
    refresh();
    got_pix.delete(); got_src.delete(); got_last.delete(); got_cyc.delete();
  endtask

  task automatic do_reset();
    clear_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic begin_frame(input logic [19:0] n);
    start = 1'b1;
    frame_pixels = n;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(done_cnt != d0), 32'(1));
    step();
  endtask

  task automatic load_test1();
    lane_q[0].push_back(20'h00080);
    lane_q[0].push_back(20'hFFFFF);
    lane_q[0].push_back(20'h08000);
    lane_q[0].push_back(20'h07F80);
    refresh();
  endtask

  task automatic load_all_lanes(input int depth);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < depth; j++) lane_q[i].push_back(20'((i*4 + j + 1) * 128));
    refresh();
  endtask

  initial begin
    int d0;
    int exp2_pix[8] = '{1, 5, 9, 13, 2, 6, 10, 14};
    int exp1_pix[4] = '{1, 0, 255, 255};
    rst = 1'b1; start = 1'b0; frame_pixels = 20'd0; out_ready = 1'b1;
    req_valid = 4'b0000; req_data = 80'd0;
`ifdef CLIP_STATS_EN
    stat_clear = 1'b0;
`endif
    step(); step(); step();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_pixel", 32'(out_pixel), 32'(0));
    check("rst_out_src", 32'(out_src), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: single lane, clamp corners
    clear_all();
    load_test1();
    d0 = done_cnt;
    begin_frame(20'd4);
    run_until_done("t1_done_timeout", 40);
    check("t1_count", 32'(got_pix.size()), 32'(4));
    for (int i = 0; i < 4 && i < got_pix.size(); i++) begin
      check("t1_pixel", 32'(got_pix[i]), 32'(exp1_pix[i]));
      check("t1_last", 32'(got_last[i]), 32'(i == 3));
    end
    check("t1_done_once", 32'(done_cnt - d0), 32'(1));

    // 2: all lanes valid, round-robin back-to-back
    do_reset();
    load_all_lanes(3);
    begin_frame(20'd8);
    run_until_done("t2_done_timeout", 40);
    check("t2_count", 32'(got_pix.size()), 32'(8));
    for (int i = 0; i < 8 && i < got_pix.size(); i++) begin
      check("t2_src", 32'(got_src[i]), 32'(i % 4));
      check("t2_pixel", 32'(got_pix[i]), 32'(exp2_pix[i]));
    end
    if (got_cyc.size() == 8) check("t2_back_to_back", 32'(got_cyc[7] - got_cyc[0]), 32'(7));

    // 3: downstream stall mid-frame
    do_reset();
    load_all_lanes(2);
    begin_frame(20'd6);
    step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_stall_req_ready", 32'(req_ready), 32'(0));
      check("t3_stall_valid", 32'(out_valid), 32'(1));
    end
    out_ready = 1'b1;
    run_until_done("t3_done_timeout", 40);
    check("t3_count", 32'(got_pix.size()), 32'(6));
    for (int i = 0; i < 6 && i < got_pix.size(); i++) begin
      check("t3_src", 32'(got_src[i]), 32'(i % 4));
      check("t3_pixel", 32'(got_pix[i]), 32'(exp2_pix[i]));
    end

    // 4: empty frame, then start while busy
    do_reset();
    begin_frame(20'd0);
    check("t4_zero_done", 32'(done), 32'(1));
    check("t4_zero_busy", 32'(busy), 32'(0));
    step();
    check("t4_zero_done_drop", 32'(done), 32'(0));
    check("t4_zero_busy2", 32'(busy), 32'(0));
    load_test1();
    d0 = done_cnt;
    begin_frame(20'd4);
    begin_frame(20'd2);
    run_until_done("t4_done_timeout", 40);
    check("t4_count", 32'(got_pix.size()), 32'(4));
    check("t4_done_once", 32'(done_cnt - d0), 32'(1));

    // 5: reset mid-frame
    do_reset();
    for (int j = 0; j < 8; j++) lane_q[0].push_back(20'((j + 1) * 128));
    refresh();
    begin_frame(20'd8);
    step(); step(); step();
    check("t5_pre_busy", 32'(busy), 32'(1));
    d0 = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_out_valid", 32'(out_valid), 32'(0));
    check("t5_req_ready", 32'(req_ready), 32'(0));
    for (int i = 0; i < 4; i++) step();
    check("t5_no_done", 32'(done_cnt - d0), 32'(0));

`ifdef CLIP_STATS_EN
    // 6: clamp statistics over two frames, then clear
    do_reset();
    for (int f = 0; f < 2; f++) begin
      load_test1();
      begin_frame(20'd4);
      run_until_done("t6_done_timeout", 40);
    end
    check("t6_neg", 32'(stat_neg_cnt), 32'(2));
    check("t6_sat", 32'(stat_sat_cnt), 32'(2));
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    check("t6_neg_clr", 32'(stat_neg_cnt), 32'(0));
    check("t6_sat_clr", 32'(stat_sat_cnt), 32'(0));
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
